// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
// Control sequencer that turns the counter datapath into a programmable
// interval timer. Configuration (period P, one-shot/periodic mode) arrives
// over a valid/ready handshake. Counting runs under start/stop control, and
// each completed P+1 cycle interval produces a one-cycle tick.
module interval_timer_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic             cfg_mode,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period_reg;
    logic             mode_reg;
    logic             cfg_accept;
    logic             at_terminal;

    // Handshake and status decode straight from the state register
    assign cfg_ready   = (state != S_RUN);
    assign busy        = (state == S_RUN);
    assign cfg_accept  = cfg_valid && cfg_ready;
    assign at_terminal = (count == period_reg);

    // Sequencer: config acceptance, start/stop control, counting and strobes
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            count      <= '0;
            period_reg <= '0;
            mode_reg   <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // tick is a strobe; only the terminal branch raises it
            tick <= 1'b0;
            if (cfg_accept) begin
                // A new configuration always wins over start in the same cycle
                period_reg <= cfg_period;
                mode_reg   <= cfg_mode;
                state      <= S_ARMED;
                count      <= '0;
                done       <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Nothing to run until a configuration has been taken
                        count <= '0;
                    end
                    S_ARMED: begin
                        if (start && !stop) begin
                            state <= S_RUN;
                            count <= '0;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            // Abort takes priority even on the terminal cycle
                            state <= S_ARMED;
                            count <= '0;
                        end else if (at_terminal) begin
                            count <= '0;
                            tick  <= 1'b1;
                            if (!mode_reg) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            // count never exceeds period_reg, so no wrap here
                            count <= count + WIDTH'(1);
                        end
                    end
                    S_DONE: begin
                        count <= '0;
                        if (start) begin
                            state <= S_RUN;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Scoreboard bench for interval_timer_ctrl: the driver updates a behavioural
// timer model at every cycle and queues the expected outputs; a monitor
// pops one entry per clock and compares it with the design.
module tb_interval_timer_ctrl;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_mode;
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             done;

    interval_timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int unsigned cnt;
        bit          tck;
        bit          bsy;
        bit          dn;
        bit          rdy;
    } exp_t;

    exp_t exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: a timer described by what it is doing, not by states
    int unsigned m_period   = 0;
    bit          m_periodic = 0;
    bit          m_have_cfg = 0;   // a configuration has been taken
    bit          m_running  = 0;   // interval in progress
    bit          m_finished = 0;   // one-shot completed, waiting for restart
    int unsigned m_count    = 0;
    bit          m_tick     = 0;
    bit          m_done     = 0;

    function automatic void model_edge(bit r, bit cv, int unsigned cp, bit cm,
                                       bit st, bit sp);
        bit ready;
        if (!r) begin
            m_period = 0; m_periodic = 0; m_have_cfg = 0;
            m_running = 0; m_finished = 0;
            m_count = 0; m_tick = 0; m_done = 0;
            return;
        end
        ready  = !m_running;
        m_tick = 0;
        if (ready && cv) begin
            m_period = cp; m_periodic = cm; m_have_cfg = 1;
            m_running = 0; m_finished = 0; m_count = 0; m_done = 0;
        end else if (m_running) begin
            if (sp) begin
                m_running = 0; m_count = 0;
            end else if (m_count == m_period) begin
                m_count = 0; m_tick = 1;
                if (!m_periodic) begin
                    m_running = 0; m_finished = 1; m_done = 1;
                end
            end else begin
                m_count = m_count + 1;
            end
        end else if (m_finished) begin
            if (st) begin
                m_finished = 0; m_running = 1; m_done = 0; m_count = 0;
            end
        end else if (m_have_cfg) begin
            if (st && !sp) begin
                m_running = 1; m_count = 0;
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue what the design should show after the edge
    task automatic cyc(bit r, bit cv, int unsigned cp, bit cm, bit st, bit sp);
        exp_t e;
        @(negedge clk);
        rst        = r;
        cfg_valid  = cv;
        cfg_period = cp[WIDTH-1:0];
        cfg_mode   = cm;
        start      = st;
        stop       = sp;
        model_edge(r, cv, cp, cm, st, sp);
        e.cnt = m_count;
        e.tck = m_tick;
        e.bsy = m_running;
        e.dn  = m_done;
        e.rdy = !m_running;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic check(string name, int unsigned act, int unsigned req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Monitor: one expected snapshot per clock edge, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count",     int'(count),     e.cnt);
                check("tick",      int'(tick),      int'(e.tck));
                check("busy",      int'(busy),      int'(e.bsy));
                check("done",      int'(done),      int'(e.dn));
                check("cfg_ready", int'(cfg_ready), int'(e.rdy));
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_mode = 1'b0;
        start = 1'b0; stop = 1'b0;

        // Reset held with start and cfg_valid asserted; then start in IDLE is ignored
        cyc(0, 1, 9, 1, 1, 0);
        cyc(0, 1, 9, 1, 1, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(2);

        // One-shot P=3
        cyc(1, 1, 3, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(7);

        // Periodic P=2 for a few intervals, then stop
        cyc(1, 1, 2, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(10);
        cyc(1, 0, 0, 0, 0, 1);

        // Periodic P=5 with stop landing on the terminal cycle, then restart
        cyc(1, 1, 5, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        guard = 0;
        while (m_count != 5 && guard < 20) begin
            idle(1);
            guard++;
        end
        cyc(1, 0, 0, 0, 0, 1);
        idle(2);
        cyc(1, 0, 0, 0, 1, 0);
        idle(8);

        // Config held during RUN, accepted once stop returns to ARMED
        cyc(1, 0, 0, 0, 0, 1);
        cyc(1, 1, 3, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 7, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 1);
        cyc(1, 1, 7, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(10);

        // Max period one-shot
        cyc(1, 1, 15, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(19);

        // Restart from DONE, and start colliding with a config in DONE
        cyc(1, 0, 0, 0, 1, 0);
        idle(18);
        cyc(1, 1, 1, 0, 1, 0);
        idle(2);

        // P=0 periodic, then reset mid-run
        cyc(1, 1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        idle(6);
        cyc(0, 0, 0, 0, 1, 0);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 5) == 0),
                $urandom_range(0, 15),
                $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 9) == 0));
        end
        idle(1);

        // Let the monitor drain the queue, bounded
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
Control sequencer for the register+adder counter datapath. Turns the free-running counter into a programmable interval timer. Accepts a period/mode configuration over a valid/ready handshake, then sequences the count under start/stop control. Emits a one-cycle terminal pulse per interval. Sits between a host/config bus and the counter datapath; consumers use tick/done as event strobes.

Parameters:
WIDTH, 4, counter and period width in bits

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  reset, synchronous, active-low
cfg_valid  in  1  configuration offered this cycle
cfg_ready  out  1  controller can accept configuration
cfg_period  in  WIDTH  terminal count P; interval length is P+1 cycles
cfg_mode  in  1  0 = one-shot, 1 = periodic (auto-reload)
start  in  1  begin/restart counting (level sampled per cycle)
stop  in  1  abort counting, return to ARMED
count  out  WIDTH  current counter value (registered)
tick  out  1  registered one-cycle pulse, one per completed interval
busy  out  1  high while in RUN
done  out  1  one-shot completed; held until restart/reconfig/reset

Behaviour:
- Reset, sampled at posedge with rst==0:
  - state=IDLE; count=0; period_reg=0; mode_reg=0.
  - tick=0; done=0; busy=0; cfg_ready=1 in the following cycle.
  - Reset overrides all other inputs, including mid-RUN.
- States: IDLE, ARMED, RUN, DONE. busy = (state==RUN). cfg_ready = (state!=RUN), combinational from state.
- Config accept: edge with cfg_valid && cfg_ready.
  - Latch period_reg=cfg_period and mode_reg=cfg_mode.
  - Next state=ARMED; count=0; done=0.
  - Accepted from IDLE, ARMED (overwrite) or DONE.
  - Never accepted in RUN; cfg_valid is ignored there and the requester must hold it.
- IDLE: start ignored (no config yet). Only config acceptance leaves IDLE.
- ARMED:
  - start && !stop -> RUN, with count=0 on entry.
  - start && stop -> stay ARMED.
  - start && cfg accept in the same cycle -> config wins; stay ARMED with the new config.
- RUN, evaluated each edge in this priority:
  1. stop=1 -> ARMED, count=0, no tick, even if count==period_reg this cycle.
  2. count==period_reg -> count=0 and tick=1 next cycle.
     - mode_reg=1: stay RUN.
     - mode_reg=0: go to DONE and set done=1.
  3. Otherwise count=count+1.
     - Width-WIDTH arithmetic; no overflow, since count never exceeds period_reg.
- tick is high for exactly one cycle per terminal event.
  - With P=0 in periodic mode, tick stays high every cycle after the first RUN cycle.
- start is ignored while in RUN (no restart mid-run).
- DONE:
  - done=1 held; count=0; cfg_ready=1.
  - start -> RUN with the same config; done cleared on that edge.
  - Config accept -> ARMED. If cfg accept and start occur together, config wins.
- Latency:
  - Start edge to first count==1: 1 cycle.
  - Terminal-count cycle to tick: 1 cycle.
  - One-shot interval from start edge to tick: P+1 cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 and cfg_valid=1 -> count=0, tick=0, done=0, busy=0; cfg_ready=1 after release; no config latched.
- One-shot P=3: accept cfg (P=3, mode=0), pulse start -> count 0,1,2,3 during RUN; tick=1 for one cycle on the next edge; done=1 and held; busy=0; count=0.
- Periodic P=2, run 9 cycles -> count sequence 0,1,2,0,1,2,0,1,2; tick pulses every 3 cycles (3 total); busy stays 1; done=0.
- Stop collision: periodic P=5; assert stop on the cycle count==5 -> no tick; state ARMED; count=0; restart via start resumes at count 0.
- Handshake: assert cfg_valid (P=7) during RUN -> cfg_ready=0, period unchanged. After stop, accept occurs on the first edge; a following start runs with P=7.
- Boundary periods and reset:
  - P=15 (max), one-shot: count reaches 15 without wrap, tick after 16 cycles.
  - P=0, periodic: tick high every cycle.
  - rst=0 asserted mid-RUN: IDLE next cycle with all outputs at reset values.
